key_mode_sel: RTL and testbench

Debounced push-button mode selector that produces the 2-bit mode select consumed by the LED controller's `sw` input, replacing the physical DIP switches. A raw active-low key is synchronised, debounced, and each confirmed press advances the mode 0→1→2→3→0. When `LONG_PRESS_EN` is defined, an optional long press returns the mode to 0. The block sits between the board key pin and `led_ctrl`, in the `sys_clk` domain.

---
 rtl/key_mode_sel.sv | 149 ++++++++++++++
 tb/tb_key_mode_sel.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_sel.sv
// key_mode_sel: debounced push-button mode selector.
// A raw active-low key is synchronised, debounced and each confirmed press
// advances a 2-bit mode 0->1->2->3->0 for led_ctrl.sw.
// Optional feature macro: LONG_PRESS_EN (a long hold returns the mode to 0).
//
// Handshake: mode_vld (and long_vld when enabled) are single-cycle,
// valid-only strobes with no ready; the consumer must sample mode in the
// cycle the strobe is high, and mode stays stable until the next strobe.
module key_mode_sel #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DB_CYCLES   = CLK_FREQ / 50,
    parameter int LONG_CYCLES = CLK_FREQ
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic [1:0] mode,
    output logic       mode_vld,
    output logic       long_vld,
    output logic       key_level,
    output logic [1:0] dbg_state
);

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    logic [1:0]      r_sync;
    logic            w_key_s;
    state_t          r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic [1:0]      r_mode;
    logic            r_mode_vld;
    logic            r_key_level;

`ifdef LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES);
    localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] HOLD_ARM  = LONG_W'(LONG_CYCLES - 2);

    logic [LONG_W-1:0] r_hold_cnt;
    logic              r_long_vld;
`endif

    // Two-flop synchroniser for the asynchronous key; idles high (released).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], key_in};
        end
    end

    assign w_key_s = r_sync[1];

    // Debounce FSM with registered mode, strobes and debounced level.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_db_cnt    <= '0;
            r_mode      <= 2'b00;
            r_mode_vld  <= 1'b0;
            r_key_level <= 1'b1;
`ifdef LONG_PRESS_EN
            r_hold_cnt  <= '0;
            r_long_vld  <= 1'b0;
`endif
        end else begin
            r_mode_vld <= 1'b0;
`ifdef LONG_PRESS_EN
            r_long_vld <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!w_key_s) begin
                        r_state  <= ST_PRESS_DB;
                        r_db_cnt <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (w_key_s) begin
                        // Low pulse shorter than the window: bounce, no event.
                        r_state <= ST_IDLE;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state     <= ST_HELD;
                        r_key_level <= 1'b0;
                        r_mode      <= r_mode + 2'd1;
                        r_mode_vld  <= 1'b1;
`ifdef LONG_PRESS_EN
                        r_hold_cnt  <= '0;
`endif
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_key_s) begin
                        r_state  <= ST_RELEASE_DB;
                        r_db_cnt <= '0;
                    end
                end
                ST_RELEASE_DB: begin
                    if (!w_key_s) begin
                        // Release bounce: still the same physical press.
                        r_state <= ST_HELD;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state     <= ST_IDLE;
                        r_key_level <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef LONG_PRESS_EN
            // Hold timer saturates, so the long event fires once per press.
            if ((r_state == ST_HELD || r_state == ST_RELEASE_DB) &&
                (r_hold_cnt != HOLD_LAST)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
                if (r_hold_cnt == HOLD_ARM) begin
                    r_mode     <= 2'b00;
                    r_mode_vld <= 1'b1;
                    r_long_vld <= 1'b1;
                end
            end
`endif
        end
    end

    assign mode      = r_mode;
    assign mode_vld  = r_mode_vld;
    assign key_level = r_key_level;
    assign dbg_state = r_state;

`ifdef LONG_PRESS_EN
    assign long_vld = r_long_vld;
`else
    assign long_vld = 1'b0;
`endif

endmodule

// File: tb/tb_key_mode_sel.sv
// tb_key_mode_sel: self-checking bench for key_mode_sel (DB=8, LONG=64).
// Edge numbering: key_in changes just after "edge 0"; edge n is the n-th
// rising edge after that point.
module tb_key_mode_sel;

  localparam int DB   = 8;
  localparam int LONG = 64;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PDB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic [1:0] mode;
  logic mode_vld;
  logic long_vld;
  logic key_level;
  logic [1:0] dbg_state;

  always #5 sys_clk = ~sys_clk;

  key_mode_sel #(
    .CLK_FREQ(400),
    .DB_CYCLES(DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .mode(mode),
    .mode_vld(mode_vld),
    .long_vld(long_vld),
    .key_level(key_level),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  int long_cnt = 0;
  logic [2:0] exp_q[$];     // {long_vld, mode} expected at each strobe
  logic [2:0] exp_v;
  logic [1:0] model_mode = 2'd0;

  always @(negedge sys_clk) begin
    if (rst_n === 1'b1 && (mode_vld === 1'b1 || long_vld === 1'b1)) begin
      vld_cnt += int'(mode_vld);
      long_cnt += int'(long_vld);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got vld=%0b long=%0b mode=%0d, expected no event",
                 mode_vld, long_vld, mode);
      end else begin
        exp_v = exp_q.pop_front();
        if ({mode_vld, long_vld, mode} !== {1'b1, exp_v}) begin
          failures++;
          $display("FAIL sb_event: got vld=%0b long=%0b mode=%0d, expected vld=1 long=%0b mode=%0d",
                   mode_vld, long_vld, mode, exp_v[2], exp_v[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_clean(input int hold);
    @(posedge sys_clk);
    #1 key_in = 1'b0;
    model_mode = model_mode + 2'd1;
    exp_q.push_back({1'b0, model_mode});
    repeat (hold) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (DB + 6) @(posedge sys_clk);
  endtask

  task automatic pulse_low(input int n);
    @(posedge sys_clk);
    #1 key_in = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (DB + 4) @(posedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_mode = 2'd0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    key_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode, mode_vld, long_vld, key_level, dbg_state} !== {2'd0, 1'b0, 1'b0, 1'b1, S_IDLE}) begin
      failures++;
      $display("FAIL reset_values: got mode=%0d vld=%0b long=%0b lvl=%0b st=%0d, expected 0 0 0 1 0",
               mode, mode_vld, long_vld, key_level, dbg_state);
    end
    rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode, key_level, dbg_state} !== {2'd0, 1'b1, S_IDLE} || vld_cnt != 0) begin
      failures++;
      $display("FAIL idle_after_reset: got mode=%0d lvl=%0b st=%0d pulses=%0d, expected 0 1 0 0",
               mode, key_level, dbg_state, vld_cnt);
    end
  endtask

  task automatic test_clean_press();
    @(posedge sys_clk);
    #1 key_in = 1'b0;
    model_mode = model_mode + 2'd1;
    exp_q.push_back({1'b0, model_mode});
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (dbg_state !== S_PDB) begin
      failures++;
      $display("FAIL press_db_entry_e3: got state=%0d, expected %0d", dbg_state, S_PDB);
    end
    repeat (7) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode_vld, mode, key_level} !== {1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL press_early_e10: got vld=%0b mode=%0d lvl=%0b, expected 0 0 1",
               mode_vld, mode, key_level);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode_vld, mode, key_level, dbg_state} !== {1'b1, 2'd1, 1'b0, S_HELD}) begin
      failures++;
      $display("FAIL press_event_e11: got vld=%0b mode=%0d lvl=%0b st=%0d, expected 1 1 0 2",
               mode_vld, mode, key_level, dbg_state);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (mode_vld !== 1'b0) begin
      failures++;
      $display("FAIL press_pulse_width: got vld=%0b at e12, expected 0", mode_vld);
    end
    repeat (8) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (key_level !== 1'b0) begin
      failures++;
      $display("FAIL release_early_e10: got lvl=%0b, expected 0", key_level);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({key_level, dbg_state} !== {1'b1, S_IDLE}) begin
      failures++;
      $display("FAIL release_e11: got lvl=%0b st=%0d, expected 1 0", key_level, dbg_state);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [4];
    int start;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    start = vld_cnt;
    for (int i = 0; i < 4; i++) begin
      press_clean(12);
      @(negedge sys_clk);
      checks++;
      if (mode !== seq[i]) begin
        failures++;
        $display("FAIL wrap_seq[%0d]: got mode=%0d, expected %0d", i, mode, seq[i]);
      end
    end
    checks++;
    if (vld_cnt - start != 4) begin
      failures++;
      $display("FAIL wrap_pulses: got %0d pulses, expected 4", vld_cnt - start);
    end
  endtask

  task automatic test_bounce();
    int start;
    start = vld_cnt;
    pulse_low(3);
    pulse_low(7);
    @(negedge sys_clk);
    checks++;
    if (vld_cnt != start || mode !== model_mode || key_level !== 1'b1) begin
      failures++;
      $display("FAIL glitch_reject: got pulses=%0d mode=%0d lvl=%0b, expected 0 %0d 1",
               vld_cnt - start, mode, key_level, model_mode);
    end
    @(posedge sys_clk);
    #1 key_in = 1'b0;
    model_mode = model_mode + 2'd1;
    exp_q.push_back({1'b0, model_mode});
    repeat (20) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1 key_in = 1'b0;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({dbg_state, key_level} !== {S_HELD, 1'b0}) begin
      failures++;
      $display("FAIL release_bounce_held: got st=%0d lvl=%0b, expected 2 0", dbg_state, key_level);
    end
    repeat (6) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (DB + 6) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (vld_cnt - start != 1 || mode !== model_mode || key_level !== 1'b1) begin
      failures++;
      $display("FAIL bounce_one_event: got pulses=%0d mode=%0d lvl=%0b, expected 1 %0d 1",
               vld_cnt - start, mode, key_level, model_mode);
    end
  endtask

  task automatic test_long_press();
    int lstart;
    while (model_mode != 2'd2) press_clean(12);
    lstart = long_cnt;
    @(posedge sys_clk);
    #1 key_in = 1'b0;
    exp_q.push_back({1'b0, 2'd3});
`ifdef LONG_PRESS_EN
    exp_q.push_back({1'b1, 2'd0});
    model_mode = 2'd0;
`else
    model_mode = 2'd3;
`endif
    repeat (11) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode_vld, mode} !== {1'b1, 2'd3}) begin
      failures++;
      $display("FAIL long_first_press: got vld=%0b mode=%0d, expected 1 3", mode_vld, mode);
    end
    repeat (62) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({long_vld, mode} !== {1'b0, 2'd3}) begin
      failures++;
      $display("FAIL long_early_h62: got long=%0b mode=%0d, expected 0 3", long_vld, mode);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
`ifdef LONG_PRESS_EN
    if ({long_vld, mode_vld, mode} !== {1'b1, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL long_event_h63: got long=%0b vld=%0b mode=%0d, expected 1 1 0",
               long_vld, mode_vld, mode);
    end
`else
    if ({long_vld, mode_vld, mode} !== {1'b0, 1'b0, 2'd3}) begin
      failures++;
      $display("FAIL hold_no_event_h63: got long=%0b vld=%0b mode=%0d, expected 0 0 3",
               long_vld, mode_vld, mode);
    end
`endif
    repeat (25) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (DB + 6) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
`ifdef LONG_PRESS_EN
    if (mode !== 2'd0 || long_cnt - lstart != 1) begin
      failures++;
      $display("FAIL long_final: got mode=%0d long_pulses=%0d, expected 0 1", mode, long_cnt - lstart);
    end
`else
    if (mode !== 2'd3 || long_cnt - lstart != 0) begin
      failures++;
      $display("FAIL hold_final: got mode=%0d long_pulses=%0d, expected 3 0", mode, long_cnt - lstart);
    end
`endif
  endtask

  task automatic test_reset_mid_press();
    if (model_mode == 2'd0) press_clean(12);
    // Reset while in PRESS_DB.
    @(posedge sys_clk);
    #1 key_in = 1'b0;
    exp_q.push_back({1'b0, model_mode + 2'd1});
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_mode = 2'd0;
    #1;
    checks++;
    if ({mode, mode_vld, long_vld, key_level, dbg_state} !== {2'd0, 1'b0, 1'b0, 1'b1, S_IDLE}) begin
      failures++;
      $display("FAIL rst_in_pdb: got mode=%0d vld=%0b long=%0b lvl=%0b st=%0d, expected 0 0 0 1 0",
               mode, mode_vld, long_vld, key_level, dbg_state);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    model_mode = 2'd1;
    exp_q.push_back({1'b0, 2'd1});
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode_vld, mode} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL rst_pdb_early_e10: got vld=%0b mode=%0d, expected 0 0", mode_vld, mode);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode_vld, mode, key_level} !== {1'b1, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL rst_pdb_repress_e11: got vld=%0b mode=%0d lvl=%0b, expected 1 1 0",
               mode_vld, mode, key_level);
    end
    // Reset while in HELD, key still low.
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_mode = 2'd0;
    #1;
    checks++;
    if ({mode, mode_vld, key_level, dbg_state} !== {2'd0, 1'b0, 1'b1, S_IDLE}) begin
      failures++;
      $display("FAIL rst_in_held: got mode=%0d vld=%0b lvl=%0b st=%0d, expected 0 0 1 0",
               mode, mode_vld, key_level, dbg_state);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    model_mode = 2'd1;
    exp_q.push_back({1'b0, 2'd1});
    repeat (11) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({mode_vld, mode} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL rst_held_repress_e11: got vld=%0b mode=%0d, expected 1 1", mode_vld, mode);
    end
    repeat (4) @(posedge sys_clk);
    #1 key_in = 1'b1;
    repeat (DB + 6) @(posedge sys_clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_wrap();
    test_bounce();
    test_long_press();
    test_reset_mid_press();
    @(negedge sys_clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending events, expected 0", exp_q.size());
    end
    checks++;
    if (mode !== model_mode) begin
      failures++;
      $display("FAIL final_mode: got mode=%0d, expected %0d", mode, model_mode);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
